// File: rtl/cc_seq_pkg.sv
// Shared types and helpers for the cc_seq_engine frame-processing core:
// FSM state encoding, derived datapath widths and result saturation.
package cc_seq_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        SORT,
        NORM,
        EQ,
        OUT
    } state_t;

    // Element width after sign/zero extension.
    function automatic int ext_width(input int data_w);
        return data_w + 1;
    endfunction

    // Width of the normalised values cu[].
    function automatic int norm_width(input int data_w);
        return data_w + 3;
    endfunction

    // Width that holds any equation intermediate without overflow.
    function automatic int prod_width(input int data_w);
        return 2 * (data_w + 3) + 1;
    endfunction

    // Clip v to the signed range of a w-bit two's complement value.
    function automatic int sat_clip(input int v, input int w);
        int hi;
        int lo;
        hi = (1 << (w - 1)) - 1;
        lo = -(1 << (w - 1));
        if (v > hi) return hi;
        if (v < lo) return lo;
        return v;
    endfunction

    // True when v lies outside the signed w-bit range.
    function automatic logic sat_hit(input int v, input int w);
        return v != sat_clip(v, w);
    endfunction

endpackage

// File: rtl/cc_cmp_swap.sv
// Combinational signed compare-exchange. With asc=1 the smaller value
// leaves on x; with asc=0 the larger one does. Equal values pass straight.
module cc_cmp_swap #(
    parameter int W = 5
) (
    input  logic signed [W-1:0] a,
    input  logic signed [W-1:0] b,
    input  logic                asc,
    output logic signed [W-1:0] x,
    output logic signed [W-1:0] y
);

    logic swap;

    // Swap only on strict inequality so equal keys keep their positions.
    always_comb begin
        swap = asc ? (a > b) : (a < b);
        x    = swap ? b : a;
        y    = swap ? a : b;
    end

endmodule

// File: rtl/cc_seq_engine.sv
// cc_seq_engine: loads N elements over valid/ready, sorts them with
// odd-even transposition, normalises them and reduces them to one
// saturated signed result presented on a valid/ready output.
// Optional build macro CC_SAT_FLAG_EN adds the sat_flag output.
module cc_seq_engine
    import cc_seq_pkg::*;
#(
    parameter int N      = 6,
    parameter int DATA_W = 4,
    parameter int OUT_W  = 10
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [DATA_W-1:0]       in_data,
    input  logic [2:0]              opt,
    input  logic                    equ,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic signed [OUT_W-1:0] out_n
`ifdef CC_SAT_FLAG_EN
    ,
    output logic                    sat_flag
`endif
);

    localparam int EW = ext_width(DATA_W);
    localparam int NW = norm_width(DATA_W);
    localparam int PW = prod_width(DATA_W);
    localparam int CW = $clog2(N + 1);
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    state_t state, state_next;
    logic [CW-1:0] cnt;
    logic [2:0]    opt_q;
    logic          equ_q;
    logic          sgn;
    logic          accept;

    logic signed [EW-1:0] a    [N];
    logic signed [EW-1:0] a_sw [N];
    logic signed [EW-1:0] px   [N/2];
    logic signed [EW-1:0] py   [N/2];
    logic signed [NW-1:0] cu   [N];
    logic signed [NW-1:0] prev;
    logic signed [NW-1:0] cu_val;
    logic signed [PW-1:0] ai_w, a0_w, prev_w, cu_w;
    logic signed [PW-1:0] diff_w, prod_v, res_w;

    function automatic logic signed [EW-1:0] extend(input logic [DATA_W-1:0] d, input logic s);
        return s ? {d[DATA_W-1], d} : {1'b0, d};
    endfunction

    function automatic logic signed [PW-1:0] div3(input logic signed [PW-1:0] v);
        logic signed [PW-1:0] three;
        three = PW'(3);
        return v / three;
    endfunction

    assign accept = in_valid && in_ready;
    assign sgn    = (state == IDLE) ? opt[0] : opt_q[0];

    // Next-state and input-ready decode.
    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_next = LOAD;
            end
            LOAD: begin
                in_ready = 1'b1;
                if (in_valid && cnt == LAST) state_next = SORT;
            end
            SORT:    if (cnt == LAST) state_next = NORM;
            NORM:    if (cnt == LAST) state_next = EQ;
            EQ:      state_next = OUT;
            OUT:     if (out_valid && out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Control registers: state, shared step counter, latched mode, output.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            opt_q     <= '0;
            equ_q     <= 1'b0;
            out_valid <= 1'b0;
            out_n     <= '0;
`ifdef CC_SAT_FLAG_EN
            sat_flag  <= 1'b0;
`endif
        end else begin
            state     <= state_next;
            out_valid <= (state == OUT) && !(out_valid && out_ready);
            case (state)
                IDLE: if (accept) begin
                    cnt   <= CW'(1);
                    opt_q <= opt;
                    equ_q <= equ;
                end
                LOAD: if (accept) cnt <= (cnt == LAST) ? '0 : cnt + CW'(1);
                SORT, NORM: cnt <= (cnt == LAST) ? '0 : cnt + CW'(1);
                EQ: begin
                    cnt   <= '0;
                    out_n <= OUT_W'(sat_clip(int'(res_w), OUT_W));
`ifdef CC_SAT_FLAG_EN
                    sat_flag <= sat_hit(int'(res_w), OUT_W);
`endif
                end
                default: cnt <= '0;
            endcase
        end
    end

    // Compare-exchange lanes; odd steps shift every lane up by one slot.
    for (genvar k = 0; k < N / 2; k++) begin : g_cs
        logic signed [EW-1:0] sx, sy;
        if (k < N / 2 - 1) begin : g_mid
            assign sx = cnt[0] ? a[2*k+1] : a[2*k];
            assign sy = cnt[0] ? a[2*k+2] : a[2*k+1];
        end else begin : g_last
            assign sx = a[2*k];
            assign sy = a[2*k+1];
        end
        cc_cmp_swap #(.W(EW)) u_cs (
            .a   (sx),
            .b   (sy),
            .asc (opt_q[1]),
            .x   (px[k]),
            .y   (py[k])
        );
    end

    // Route lane results back into the array for the current step parity.
    always_comb begin
        for (int i = 0; i < N; i++) a_sw[i] = a[i];
        if (!cnt[0]) begin
            for (int k = 0; k < N / 2; k++) begin
                a_sw[2*k]   = px[k];
                a_sw[2*k+1] = py[k];
            end
        end else begin
            for (int k = 0; k < N / 2 - 1; k++) begin
                a_sw[2*k+1] = px[k];
                a_sw[2*k+2] = py[k];
            end
        end
    end

    // Normalisation of element cnt: running average or offset from a[0].
    always_comb begin
        ai_w   = PW'(a[cnt]);
        a0_w   = PW'(a[0]);
        prev_w = PW'(prev);
        if (opt_q[2]) cu_w = (cnt == '0) ? ai_w : div3(prev_w + prev_w + ai_w);
        else          cu_w = ai_w - a0_w;
        cu_val = NW'(cu_w);
    end

    // Equation reduction at full precision before saturation.
    always_comb begin
        diff_w = PW'(cu[1]) - PW'(cu[0]);
        prod_v = PW'(cu[N-1]) * diff_w;
        if (equ_q) res_w = (prod_v < 0) ? -prod_v : prod_v;
        else       res_w = div3(PW'(cu[N-3]) + (PW'(cu[N-2]) <<< 2));
    end

    // Element storage, sort steps and normalised values; data needs no reset.
    always_ff @(posedge clk) begin
        if (accept) a[cnt] <= extend(in_data, sgn);
        if (state == SORT) begin
            for (int i = 0; i < N; i++) a[i] <= a_sw[i];
        end
        if (state == NORM) begin
            cu[cnt] <= cu_val;
            prev    <= cu_val;
        end
    end

endmodule
